// File: rtl/prod_accumulator.sv
// Sums a programmed number of consecutive products into a wide accumulator and
// presents the result through a valid/ready handshake. clk_en freezes the whole block.
//
// state | meaning
// IDLE  | waiting for start; acc_out keeps the last finished sum
// ACCUM | adding products, cnt counts the ones still expected
// HOLD  | sum presented on acc_out with acc_valid, waiting for acc_ready
module prod_accumulator #(
  parameter int PW = 128,
  parameter int CW = 8,
  parameter int AW = PW + CW
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          start,
  input  logic [CW-1:0] len,
  input  logic          p_valid,
  input  logic [PW-1:0] p,
  output logic          busy,
  output logic          acc_valid,
  input  logic          acc_ready,
  output logic [AW-1:0] acc_out,
  output logic          drop
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t        state;
  logic [AW-1:0] acc;
  // One extra bit so that len==0 can load the full 2^CW block length.
  logic [CW:0]   cnt;

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      acc_valid <= 1'b0;
      drop      <= 1'b0;
    end else if (!clk_en) begin
      drop <= 1'b0;
    end else begin
      drop <= p_valid && (state != ACCUM);
      case (state)
        IDLE: begin
          if (start) begin
            acc   <= '0;
            cnt   <= (len == '0) ? {1'b1, {CW{1'b0}}} : {1'b0, len};
            state <= ACCUM;
            busy  <= 1'b1;
          end
        end
        ACCUM: begin
          if (p_valid) begin
            acc <= acc + AW'(p);
            cnt <= cnt - (CW+1)'(1);
            if (cnt == (CW+1)'(1)) begin
              state     <= HOLD;
              acc_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (acc_ready) begin
            state     <= IDLE;
            busy      <= 1'b0;
            acc_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          acc_valid <= 1'b0;
        end
      endcase
    end
  end

  assign acc_out = acc;

endmodule

// File: tb/tb_prod_accumulator.sv
// Directed and randomized checks of prod_accumulator against a block-level
// model of the accumulate/handshake behaviour.
module tb_prod_accumulator;

  localparam int PW = 128;
  localparam int CW = 8;
  localparam int AW = PW + CW;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          clk_en = 1'b1;
  logic          start = 1'b0;
  logic [CW-1:0] len = '0;
  logic          p_valid = 1'b0;
  logic [PW-1:0] p = '0;
  logic          busy;
  logic          acc_valid;
  logic          acc_ready = 1'b1;
  logic [AW-1:0] acc_out;
  logic          drop;

  prod_accumulator #(.PW(PW), .CW(CW), .AW(AW)) dut (
    .clk_in(clk_in), .rst(rst), .clk_en(clk_en), .start(start), .len(len),
    .p_valid(p_valid), .p(p), .busy(busy), .acc_valid(acc_valid),
    .acc_ready(acc_ready), .acc_out(acc_out), .drop(drop)
  );

  always #5 clk_in = ~clk_in;

  int total = 0;
  int bad = 0;
  int busy_cnt = 0;
  int valid_cnt = 0;

  // Block-level model: is a block open, is its sum finished, products still owed.
  bit            m_busy = 0;
  bit            m_done = 0;
  int            m_left = 0;
  logic [AW-1:0] m_sum = '0;
  bit            m_drop = 0;

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_busy = 0; m_done = 0; m_left = 0; m_sum = '0; m_drop = 0;
    end else if (!clk_en) begin
      m_drop = 0;
    end else begin
      m_drop = p_valid && !(m_busy && !m_done);
      if (!m_busy) begin
        if (start) begin
          m_busy = 1;
          m_sum  = '0;
          m_left = (len == 0) ? 256 : int'(len);
        end
      end else if (!m_done) begin
        if (p_valid) begin
          m_sum  = m_sum + {{(AW-PW){1'b0}}, p};
          m_left = m_left - 1;
          if (m_left == 0) m_done = 1;
        end
      end else if (acc_ready) begin
        m_busy = 0;
        m_done = 0;
      end
    end
  endtask

  // One clock: model follows the edge, outputs are compared at the falling edge.
  task automatic step();
    @(posedge clk_in);
    model_edge();
    @(negedge clk_in);
    check("busy", AW'(busy), AW'(m_busy));
    check("acc_valid", AW'(acc_valid), AW'(m_done));
    check("acc_out", acc_out, m_sum);
    check("drop", AW'(drop), AW'(m_drop));
    if (busy) busy_cnt++;
    if (acc_valid) valid_cnt++;
  endtask

  task automatic idle_inputs();
    start = 0; p_valid = 0; clk_en = 1; rst = 0; acc_ready = 1; p = '0;
  endtask

  logic [PW-1:0] big_prod;
  logic [AW-1:0] lit;

  initial begin
    @(negedge clk_in);
    rst = 1;
    step();
    step();
    check("reset_busy", AW'(busy), '0);
    check("reset_acc_valid", AW'(acc_valid), '0);
    check("reset_acc_out", acc_out, '0);
    check("reset_drop", AW'(drop), '0);
    idle_inputs();
    step();

    // Basic block of three products with acc_ready held high.
    busy_cnt = 0; valid_cnt = 0;
    start = 1; len = 3; step();
    start = 0; p_valid = 1;
    p = 5; step();
    p = 7; step();
    check("t1_not_yet_valid", AW'(acc_valid), '0);
    p = 11; step();
    check("t1_sum", acc_out, 136'd23);
    check("t1_valid_now", AW'(acc_valid), 136'd1);
    p_valid = 0; step();
    step();
    check("t1_busy_span", AW'(busy_cnt), 136'd4);
    check("t1_valid_span", AW'(valid_cnt), 136'd1);
    check("t1_sum_kept", acc_out, 136'd23);

    // Full-length block of all-ones products.
    start = 1; len = 0; step();
    start = 0; p_valid = 1; p = '1;
    for (int i = 0; i < 256; i++) step();
    lit = {{128{1'b1}}, 8'h00};
    check("t2_full_sum", acc_out, lit);
    p_valid = 0; step();

    // Large product, gap, then 1.
    big_prod = 128'(64'd8563214857120369541) * 128'(64'd6579858412322574896);
    start = 1; len = 2; step();
    start = 0; p_valid = 1; p = big_prod; step();
    p_valid = 0;
    for (int i = 0; i < 3; i++) step();
    check("t3_gap_no_finish", AW'(acc_valid), '0);
    p_valid = 1; p = 1; step();
    check("t3_sum", acc_out, {8'h00, big_prod} + 136'd1);
    p_valid = 0; step();

    // Stalled HOLD with stray product and start.
    start = 1; len = 1; step();
    start = 0; p_valid = 1; p = 42; acc_ready = 0; step();
    p_valid = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) p_valid = 1;
      if (i == 2) begin p_valid = 0; start = 1; len = 7; end
      if (i == 3) start = 0;
      step();
      if (i == 1) check("t4_drop_in_hold", AW'(drop), 136'd1);
    end
    check("t4_sum_stable", acc_out, 136'd42);
    check("t4_still_valid", AW'(acc_valid), 136'd1);
    acc_ready = 1; step();
    check("t4_back_idle", AW'(busy), '0);
    step();

    // clk_en low mid-block while products keep arriving.
    start = 1; len = 3; step();
    start = 0; p_valid = 1; p = 1; step();
    clk_en = 0; p = 100;
    for (int i = 0; i < 4; i++) begin
      step();
      check("t5_no_drop", AW'(drop), '0);
    end
    clk_en = 1; p = 2; step();
    p = 4; step();
    check("t5_sum", acc_out, 136'd7);
    p_valid = 0; step();

    // Reset partway through a block.
    start = 1; len = 4; step();
    start = 0; p_valid = 1; p = 3; step();
    step();
    p_valid = 0; rst = 1; step();
    rst = 0;
    check("t6_reset_busy", AW'(busy), '0);
    check("t6_reset_sum", acc_out, '0);
    start = 1; len = 1; step();
    start = 0; p_valid = 1; p = 9; step();
    check("t6_sum", acc_out, 136'd9);
    p_valid = 0; step();

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      rst       = ($urandom_range(0, 199) == 0);
      clk_en    = ($urandom_range(0, 9) != 0);
      start     = ($urandom_range(0, 3) == 0);
      len       = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 6));
      p_valid   = ($urandom_range(0, 9) < 7);
      p         = {$urandom(), $urandom(), $urandom(), $urandom()};
      acc_ready = $urandom_range(0, 1) == 1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
